// File: rtl/mano_p_pkg.sv
// Shared types and constants for the Mano-style accumulator core:
// opcode and FSM state encodings, register-reference bit positions,
// and the memory-reference dispatch rule.
package mano_p_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_RRF = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_INDIRECT = 3'd2,
        S_READ     = 3'd3,
        S_WRITE    = 3'd4,
        S_EXEC     = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    // Register-reference bit positions within IR[11:0]
    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    // Where a memory-reference instruction goes once its effective address is known
    function automatic state_t dispatch(input opcode_t op);
        case (op)
            OP_STA, OP_BSA: return S_WRITE;
            OP_BUN:         return S_EXEC;
            default:        return S_READ;  // AND, ADD, LDA, ISZ
        endcase
    endfunction

endpackage

// File: rtl/mano_alu_p.sv
// Combinational datapath for the core: AND, add-with-carry, operand
// increment (ISZ), and the ordered register-reference chain
// (clear, complement, rotate, increment) plus the skip test.
module mano_alu_p
    import mano_p_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] ac,
    input  logic          e_in,
    input  logic [DW-1:0] md,
    input  logic [11:1]   rr,
    output logic [DW-1:0] and_ac,
    output logic [DW-1:0] add_ac,
    output logic          add_e,
    output logic [DW-1:0] md_inc,
    output logic [DW-1:0] rr_ac,
    output logic          rr_e,
    output logic          rr_skip
);

    assign and_ac           = ac & md;
    assign {add_e, add_ac}  = {1'b0, ac} + {1'b0, md};
    assign md_inc           = md + DW'(1);

    // Skips look at the accumulator/extend values from before this instruction
    assign rr_skip = (rr[RR_SPA] & ~ac[DW-1]) |
                     (rr[RR_SNA] &  ac[DW-1]) |
                     (rr[RR_SZA] & (ac == '0)) |
                     (rr[RR_SZE] & ~e_in);

    // Apply register-reference micro-ops in fixed order; later ops see earlier results
    always_comb begin
        rr_ac = ac;
        rr_e  = e_in;
        if (rr[RR_CLA]) rr_ac = '0;
        if (rr[RR_CLE]) rr_e  = 1'b0;
        if (rr[RR_CMA]) rr_ac = ~rr_ac;
        if (rr[RR_CME]) rr_e  = ~rr_e;
        if (rr[RR_CIR]) {rr_ac, rr_e} = {rr_e, rr_ac};
        if (rr[RR_CIL]) {rr_e, rr_ac} = {rr_ac, rr_e};
        if (rr[RR_INC]) rr_ac = rr_ac + DW'(1);
    end

endmodule

// File: rtl/mano_core_p.sv
// Multi-cycle Mano-style accumulator core with a request/acknowledge
// memory port. One access in flight at a time; request and its
// address/data are decoded from the registered state so they stay
// stable for as long as the memory stalls.
module mano_core_p
    import mano_p_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 12,
    parameter int RESET_PC = 0
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    input  logic          resume,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] ar,
    output logic [DW-1:0] ac,
    output logic [DW-1:0] ir,
    output logic          e
);

    state_t        state;
    logic [DW-1:0] dr;        // ISZ incremented operand awaiting write-back
    opcode_t       op;
    logic          ind;

    logic [DW-1:0] and_ac, add_ac, md_inc, rr_ac;
    logic          add_e, rr_e, rr_skip;
    logic          mem_state;

    assign op  = opcode_t'(ir[DW-2:DW-4]);
    assign ind = ir[DW-1];

    mano_alu_p #(.DW(DW)) u_alu (
        .ac      (ac),
        .e_in    (e),
        .md      (mem_rdata),
        .rr      (ir[11:1]),
        .and_ac  (and_ac),
        .add_ac  (add_ac),
        .add_e   (add_e),
        .md_inc  (md_inc),
        .rr_ac   (rr_ac),
        .rr_e    (rr_e),
        .rr_skip (rr_skip)
    );

    // Bus outputs follow the registered state; gating with RST_N drops the
    // request the moment reset asserts and keeps it low while reset is held.
    assign mem_state = (state == S_FETCH) || (state == S_INDIRECT) ||
                       (state == S_READ)  || (state == S_WRITE);
    assign mem_req   = RST_N && mem_state;
    assign mem_we    = RST_N && (state == S_WRITE);
    assign mem_addr  = (state == S_FETCH) ? pc : ar;
    assign halted    = (state == S_HALT);

    // Write data source depends on which instruction owns the WRITE state
    always_comb begin
        mem_wdata = ac;
        case (op)
            OP_ISZ:  mem_wdata = dr;
            OP_BSA:  mem_wdata = {{(DW-AW){1'b0}}, pc};
            default: mem_wdata = ac;
        endcase
    end

    // Instruction sequencer: fetch, decode, operand access and execute
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_FETCH;
            pc    <= AW'(RESET_PC);
            ar    <= '0;
            ac    <= '0;
            ir    <= '0;
            e     <= 1'b0;
            dr    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + AW'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ar <= ir[AW-1:0];
                    if (op == OP_RRF) begin
                        // I=1 with opcode 7 is a NOP
                        if (!ind) begin
                            ac <= rr_ac;
                            e  <= rr_e;
                            if (rr_skip) pc <= pc + AW'(1);
                        end
                        state <= (!ind && ir[RR_HLT]) ? S_HALT : S_FETCH;
                    end else if (ind) begin
                        state <= S_INDIRECT;
                    end else begin
                        state <= dispatch(op);
                    end
                end
                S_INDIRECT: begin
                    if (mem_ack) begin
                        ar    <= mem_rdata[AW-1:0];
                        state <= dispatch(op);
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        state <= S_FETCH;
                        case (op)
                            OP_AND: ac <= and_ac;
                            OP_ADD: begin
                                ac <= add_ac;
                                e  <= add_e;
                            end
                            OP_LDA: ac <= mem_rdata;
                            OP_ISZ: begin
                                dr    <= md_inc;
                                state <= S_WRITE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        if (op == OP_ISZ && dr == '0) pc <= pc + AW'(1);
                        else if (op == OP_BSA)         pc <= ar + AW'(1);
                        state <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    pc    <= ar;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (resume) state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mano_core_p.sv
// Bench for mano_core_p: directed scenarios plus random programs checked
// against an instruction-level model of the machine.
module tb_mano_core_p;

    logic        CLK;
    logic        RST_N;
    logic        mem_req, mem_we, mem_ack, resume, halted, e;
    logic [11:0] mem_addr, pc, ar;
    logic [15:0] mem_wdata, mem_rdata, ac, ir;

    logic [15:0] mem [4096];
    logic [15:0] img [4096];
    int          mm  [4096];
    logic        load;
    logic        ack_idle;
    logic        rand_mode;
    int          base_delay;
    int          rnd_delay = 0;
    int          cnt = 0;

    int checks = 0;
    int errors = 0;

    mano_core_p #(.DW(16), .AW(12), .RESET_PC(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .resume(resume), .halted(halted), .pc(pc),
        .ar(ar), .ac(ac), .ir(ir), .e(e)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory with programmable ack latency; image loaded in one edge
    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) mem[i] <= img[i];
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_req && mem_ack) begin
            cnt <= 0;
            rnd_delay <= $urandom_range(0, 3);
        end else if (mem_req) cnt <= cnt + 1;
        else cnt <= 0;
    end
    assign mem_ack   = mem_req ? (cnt >= (rand_mode ? rnd_delay : base_delay)) : ack_idle;
    assign mem_rdata = mem[mem_addr];

    task automatic clear_img();
        for (int i = 0; i < 4096; i++) img[i] = 16'h7001;
    endtask

    task automatic start_run();
        RST_N  = 1'b0;
        resume = 1'b0;
        load   = 1'b1;
        @(posedge CLK); #1;
        load = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic wait_halt(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(posedge CLK); #1;
            cyc++;
            if (halted) ok = 1'b1;
        end
    endtask

    // Instruction-level model: runs img until HLT, returns final state and zero-wait cycle total
    task automatic model_run(output int mac, output int me, output int mpc, output int mcyc);
        int inst, opc, adr, sum, v, t;
        bit ind, skip, done;
        for (int i = 0; i < 4096; i++) mm[i] = int'(img[i]);
        mac = 0; me = 0; mpc = 0; mcyc = 0; done = 0;
        for (int step = 0; step < 300 && !done; step++) begin
            inst = mm[mpc];
            mpc  = (mpc + 1) % 4096;
            mcyc += 2;
            ind = inst[15];
            opc = (inst >> 12) & 7;
            adr = inst & 12'hFFF;
            if (opc == 7) begin
                if (!ind) begin
                    skip = (inst[4] && mac < 32768) || (inst[3] && mac >= 32768) ||
                           (inst[2] && mac == 0) || (inst[1] && me == 0);
                    if (inst[11]) mac = 0;
                    if (inst[10]) me = 0;
                    if (inst[9])  mac = 65535 - mac;
                    if (inst[8])  me = 1 - me;
                    if (inst[7]) begin
                        v = mac * 2 + me;
                        v = (v >> 1) + (v % 2) * 65536;
                        mac = v >> 1; me = v % 2;
                    end
                    if (inst[6]) begin
                        v = mac * 2 + me;
                        v = ((v * 2) % 131072) + (v >> 16);
                        mac = v >> 1; me = v % 2;
                    end
                    if (inst[5]) mac = (mac + 1) % 65536;
                    if (skip) mpc = (mpc + 1) % 4096;
                    if (inst[0]) done = 1;
                end
            end else begin
                if (ind) begin
                    adr = mm[adr] % 4096;
                    mcyc += 1;
                end
                case (opc)
                    0: begin mac = mac & mm[adr]; mcyc += 1; end
                    1: begin sum = mac + mm[adr]; me = sum / 65536; mac = sum % 65536; mcyc += 1; end
                    2: begin mac = mm[adr]; mcyc += 1; end
                    3: begin mm[adr] = mac; mcyc += 1; end
                    4: begin mpc = adr; mcyc += 1; end
                    5: begin mm[adr] = mpc; mpc = (adr + 1) % 4096; mcyc += 1; end
                    default: begin
                        t = (mm[adr] + 1) % 65536;
                        mm[adr] = t;
                        if (t == 0) mpc = (mpc + 1) % 4096;
                        mcyc += 2;
                    end
                endcase
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #2;
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", pc); end
        checks++; if (ac !== 16'h0) begin errors++; $display("FAIL reset_ac got %h exp 0000", ac); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL reset_e got %b exp 0", e); end
        checks++; if (ir !== 16'h0) begin errors++; $display("FAIL reset_ir got %h exp 0000", ir); end
        checks++; if (ar !== 12'h0) begin errors++; $display("FAIL reset_ar got %h exp 000", ar); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_req got req=%b we=%b exp 0 0", mem_req, mem_we); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    endtask

    task automatic test_lda_direct();
        clear_img();
        img[0] = 16'h2004; img[4] = 16'h1234;
        base_delay = 0; rand_mode = 0; ack_idle = 0;
        start_run();
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin errors++; $display("FAIL first_req got req=%b addr=%h exp 1 000", mem_req, mem_addr); end
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (ac !== 16'h1234) begin errors++; $display("FAIL lda_ac got %h exp 1234", ac); end
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL lda_pc got %h exp 001", pc); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h001) begin errors++; $display("FAIL lda_next_fetch got req=%b addr=%h exp 1 001", mem_req, mem_addr); end
    endtask

    task automatic test_lda_indirect();
        clear_img();
        img[0] = 16'hA004; img[4] = 16'h0008; img[8] = 16'hBEEF;
        base_delay = 0; rand_mode = 0; ack_idle = 0;
        start_run();
        repeat (4) @(posedge CLK);
        #1;
        checks++; if (ac !== 16'hBEEF || ar !== 12'h008) begin errors++; $display("FAIL lda_ind got ac=%h ar=%h exp BEEF 008", ac, ar); end
    endtask

    task automatic test_add_carry();
        int cyc; bit ok;
        clear_img();
        img[0] = 16'h7800; img[1] = 16'h7200; img[2] = 16'h1010; img[16] = 16'h0001;
        base_delay = 1; rand_mode = 0; ack_idle = 0;
        start_run();
        wait_halt(200, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_halt_timeout got running exp halted"); end
        checks++; if (ac !== 16'h0000 || e !== 1'b1) begin errors++; $display("FAIL add_carry got ac=%h e=%b exp 0000 1", ac, e); end
    endtask

    task automatic test_sta_indirect();
        int cyc; bit ok; bit found;
        clear_img();
        img[0] = 16'h2011; img[1] = 16'hB010; img[16] = 16'h0020; img[17] = 16'h5A5A;
        base_delay = 3; rand_mode = 0; ack_idle = 0;
        start_run();
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge CLK);
            if (mem_req && mem_we) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL sta_write_timeout got no write exp write"); end
        for (int w = 0; w < 4; w++) begin
            if (w > 0) @(negedge CLK);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h020 || mem_wdata !== 16'h5A5A) begin
                errors++;
                $display("FAIL sta_stable cyc%0d got req=%b we=%b addr=%h data=%h exp 1 1 020 5A5A", w, mem_req, mem_we, mem_addr, mem_wdata);
            end
        end
        @(negedge CLK);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL sta_done got we=%b exp 0", mem_we); end
        wait_halt(200, cyc, ok);
        checks++; if (!ok || mem[12'h020] !== 16'h5A5A) begin errors++; $display("FAIL sta_mem got %h halted=%b exp 5A5A 1", mem[12'h020], ok); end
    endtask

    task automatic test_isz();
        int cyc; bit ok;
        clear_img();
        img[0] = 16'h4030; img[12'h030] = 16'h6040; img[12'h040] = 16'hFFFF;
        base_delay = 0; rand_mode = 0; ack_idle = 0;
        start_run();
        wait_halt(200, cyc, ok);
        checks++; if (!ok || pc !== 12'h033) begin errors++; $display("FAIL isz_skip got pc=%h halted=%b exp 033 1", pc, ok); end
        checks++; if (mem[12'h040] !== 16'h0000) begin errors++; $display("FAIL isz_mem got %h exp 0000", mem[12'h040]); end
        // BUN 3 + ISZ 4 + HLT 2
        checks++; if (cyc !== 9) begin errors++; $display("FAIL isz_cycles got %0d exp 9", cyc); end
    endtask

    task automatic test_bsa();
        int cyc; bit ok;
        clear_img();
        img[0] = 16'h4050; img[12'h050] = 16'h5100; img[12'h100] = 16'h0000;
        base_delay = 2; rand_mode = 0; ack_idle = 0;
        start_run();
        wait_halt(300, cyc, ok);
        checks++; if (!ok || pc !== 12'h102) begin errors++; $display("FAIL bsa_pc got pc=%h halted=%b exp 102 1", pc, ok); end
        checks++; if (mem[12'h100] !== 16'h0051) begin errors++; $display("FAIL bsa_mem got %h exp 0051", mem[12'h100]); end
    endtask

    task automatic test_halt_resume();
        int cyc; bit ok;
        clear_img();
        img[0] = 16'h7001; img[1] = 16'h7020;
        base_delay = 0; rand_mode = 0; ack_idle = 1;
        start_run();
        wait_halt(20, cyc, ok);
        checks++; if (!ok || cyc !== 2) begin errors++; $display("FAIL hlt_latency got %0d halted=%b exp 2 1", cyc, ok); end
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 12'h001) begin errors++; $display("FAIL halt_hold got halted=%b req=%b pc=%h exp 1 0 001", halted, mem_req, pc); end
        @(negedge CLK);
        resume = 1'b1;
        @(posedge CLK); #1;
        resume = 1'b0;
        checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 12'h001) begin errors++; $display("FAIL resume_fetch got halted=%b req=%b addr=%h exp 0 1 001", halted, mem_req, mem_addr); end
        wait_halt(20, cyc, ok);
        checks++; if (!ok || ac !== 16'h0001 || pc !== 12'h003) begin errors++; $display("FAIL resume_run got ac=%h pc=%h exp 0001 003", ac, pc); end
        ack_idle = 0;
    endtask

    task automatic test_reset_mid_read();
        bit found;
        clear_img();
        img[0] = 16'h2004; img[4] = 16'h1234;
        base_delay = 5; rand_mode = 0; ack_idle = 0;
        start_run();
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge CLK);
            if (mem_req && !mem_we && mem_addr == 12'h004) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midrd_timeout got no read exp read"); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midrd_req got %b exp 0", mem_req); end
        checks++; if (pc !== 12'h000 || ac !== 16'h0 || ir !== 16'h0 || ar !== 12'h0) begin errors++; $display("FAIL midrd_regs got pc=%h ac=%h ir=%h ar=%h exp 0", pc, ac, ir, ar); end
    endtask

    task automatic test_random();
        int n, mac, me, mpc, mcyc, cyc, sel;
        bit ok;
        logic [2:0]  opc;
        logic        ind;
        logic [11:0] adr;
        for (int trial = 0; trial < 30; trial++) begin
            clear_img();
            for (int k = 0; k < 8; k++) begin
                sel = $urandom_range(0, 3);
                img[12'h100 + k] = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0000 : 16'($urandom);
                img[12'h080 + k] = 16'h0100 + 16'($urandom_range(0, 7));
            end
            n = $urandom_range(4, 14);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    img[k] = 16'h7000 | 16'($urandom_range(0, 2047) << 1);
                end else begin
                    sel = $urandom_range(0, 4);
                    opc = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd1 : (sel == 2) ? 3'd2 : (sel == 3) ? 3'd3 : 3'd6;
                    ind = 1'($urandom_range(0, 1));
                    adr = (ind ? 12'h080 : 12'h100) + 12'($urandom_range(0, 7));
                    img[k] = {ind, opc, adr};
                end
            end
            model_run(mac, me, mpc, mcyc);
            rand_mode  = (trial % 2 == 1);
            base_delay = 0;
            ack_idle   = 1'($urandom_range(0, 1));
            start_run();
            wait_halt(3000, cyc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout got running exp halted", trial); end
            checks++; if (ac !== 16'(mac) || e !== 1'(me)) begin errors++; $display("FAIL rnd%0d_acc got ac=%h e=%b exp %h %0d", trial, ac, e, 16'(mac), me); end
            checks++; if (pc !== 12'(mpc)) begin errors++; $display("FAIL rnd%0d_pc got %h exp %h", trial, pc, 12'(mpc)); end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (mem[12'h100 + k] !== 16'(mm[12'h100 + k])) begin
                    errors++;
                    $display("FAIL rnd%0d_mem%0d got %h exp %h", trial, k, mem[12'h100 + k], 16'(mm[12'h100 + k]));
                end
            end
            if (!rand_mode) begin
                checks++; if (cyc !== mcyc) begin errors++; $display("FAIL rnd%0d_cycles got %0d exp %0d", trial, cyc, mcyc); end
            end
        end
        ack_idle = 0;
        rand_mode = 0;
    endtask

    initial begin
        RST_N = 1'b0; resume = 1'b0; load = 1'b0;
        ack_idle = 1'b0; rand_mode = 1'b0; base_delay = 0;
        test_reset();
        test_lda_direct();
        test_lda_indirect();
        test_add_carry();
        test_sta_indirect();
        test_isz();
        test_bsa();
        test_halt_resume();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
